// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime-selectable parity, 1/2 stop bits, line break
// and a frame-done pulse. Bit period is prescale*8 clk cycles.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic                  break_req
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [15:0]           presc_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  stop_left_q;
  logic [18:0]           timer_q;
  logic [3:0]            bit_cnt_q;
  logic                  txd_q;
  logic                  tready_q;
  logic                  busy_q;
  logic                  done_q;

  logic [15:0] presc_in;
  logic [18:0] load_in;
  logic [18:0] load_cap;
  logic        bit_end;
  logic        accept;

  assign presc_in = (prescale == 16'd0) ? 16'd1 : prescale;
  assign load_in  = {presc_in, 3'b000} - 19'd1;
  assign load_cap = {presc_q, 3'b000} - 19'd1;
  assign bit_end  = (timer_q == 19'd0);
  assign accept   = tready_q && s_axis_tvalid && !break_req;

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;
  assign tx_done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      presc_q     <= 16'd1;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      txd_q       <= 1'b1;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (break_req) begin
            state_q  <= S_BREAK;
            txd_q    <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b1;
          end else if (accept) begin
            // Whole frame configuration is frozen here; later input changes are ignored.
            shift_q   <= s_axis_tdata;
            presc_q   <= presc_in;
            par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_q <= (^s_axis_tdata) ^ (parity_mode == 2'b10);
            stop2_q   <= stop_bits;
            timer_q   <= load_in;
            state_q   <= S_START;
            txd_q     <= 1'b0;
            tready_q  <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            txd_q    <= 1'b1;
            tready_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            txd_q     <= shift_q[0];
            bit_cnt_q <= LAST_BIT;
            timer_q   <= load_cap;
          end else begin
            timer_q <= timer_q - 19'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer_q <= load_cap;
            if (bit_cnt_q == 4'd0) begin
              if (par_en_q) begin
                state_q <= S_PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q     <= S_STOP;
                txd_q       <= 1'b1;
                stop_left_q <= stop2_q;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q - 4'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - 19'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q     <= S_STOP;
            txd_q       <= 1'b1;
            stop_left_q <= stop2_q;
            timer_q     <= load_cap;
          end else begin
            timer_q <= timer_q - 19'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_left_q) begin
              stop_left_q <= 1'b0;
              timer_q     <= load_cap;
            end else begin
              state_q  <= S_IDLE;
              txd_q    <= 1'b1;
              tready_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - 19'd1;
            // Registered pulse lands on the final cycle of the last stop bit.
            if (!stop_left_q && (timer_q == 19'd1)) begin
              done_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (!break_req) begin
            state_q  <= S_IDLE;
            txd_q    <= 1'b1;
            tready_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          txd_q    <= 1'b1;
          tready_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table vectors, corner sequences and
// randomized frames checked against a bit-list frame model.
module tb_uart_tx_cfg;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          txd;
  logic          busy;
  logic          tx_done;
  logic [15:0]   prescale = 16'd1;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop_bits = 1'b0;
  logic          break_req = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  uart_tx_cfg #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .txd(txd), .busy(busy), .tx_done(tx_done),
    .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .break_req(break_req)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] presc;
    logic [1:0]  pmode;
    logic        stop;
    logic [15:0] mid_presc;
    logic [1:0]  mid_pmode;
    logic        mid_stop;
    logic        exp_has_par;
    logic        exp_par;
    int          exp_len;
  } vec_t;

  vec_t tbl[8];

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame as a list of line levels, one per bit period: start, data LSB first, parity, stops.
  function automatic logic [15:0] build_bits(input logic [7:0] d, input logic has_par,
                                             input logic par, input logic two_stop,
                                             output int nbits);
    logic [15:0] pat;
    int k;
    pat = '1;
    pat[0] = 1'b0;
    k = 1;
    for (int i = 0; i < DW; i++) begin
      pat[k] = d[i];
      k++;
    end
    if (has_par) begin
      pat[k] = par;
      k++;
    end
    k = k + (two_stop ? 2 : 1);
    nbits = k;
    return pat;
  endfunction

  task automatic start_word(input logic [7:0] d, input logic [15:0] p, input logic [1:0] pm,
                            input logic st, output logic ok);
    s_axis_tdata  = d;
    prescale      = p;
    parity_mode   = pm;
    stop_bits     = st;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 400 && !s_axis_tready; i++) @(negedge clk);
    ok = s_axis_tready;
    if (!ok) begin
      check_eq("accept_timeout", 0, 1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [15:0] p, input logic [1:0] pm,
                           input logic st, input logic [15:0] mp, input logic [1:0] mpm,
                           input logic mst, input logic mbrk, input logic [15:0] pat,
                           input int nbits, input int exp_len, input string tag);
    logic ok;
    logic [0:0] e;
    int bp, n, mism, done_cnt, done_at, bad_rdy, bad_busy;
    start_word(d, p, pm, st, ok);
    if (!ok) return;
    bp = exp_len / nbits;
    for (int k = 0; k < nbits; k++) exp_q.push_back(pat[k]);
    n = 0; done_cnt = 0; done_at = 0; bad_rdy = 0; bad_busy = 0;
    for (int k = 0; k < nbits; k++) begin
      e = exp_q.pop_front();
      mism = 0;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk);
        n++;
        if (n == 5) begin
          prescale    = mp;
          parity_mode = mpm;
          stop_bits   = mst;
          break_req   = mbrk;
        end
        if (txd !== e) mism++;
        if (tx_done) begin
          done_cnt++;
          done_at = n;
        end
        if (s_axis_tready) bad_rdy++;
        if (!busy) bad_busy++;
      end
      check_eq($sformatf("%s bit%0d txd mismatches", tag, k), mism, 0);
    end
    check_eq({tag, " tx_done count"}, done_cnt, 1);
    check_eq({tag, " tx_done cycle"}, done_at, exp_len);
    check_eq({tag, " tready high in frame"}, bad_rdy, 0);
    check_eq({tag, " busy low in frame"}, bad_busy, 0);
    @(negedge clk);
    check_eq({tag, " post idle {txd,busy,tready,done}"},
             int'({txd, busy, s_axis_tready, tx_done}), int'(4'b1010));
  endtask

  initial begin
    logic [15:0] pat;
    int nbits, p_eff, ones, fall1, fall2, rdy_cnt, done_cnt, done_last, mism, bad, n;
    logic has_par, par, prev, ok, seen_rdy;
    logic [7:0]  rd;
    logic [15:0] rp;
    logic [1:0]  rpm;
    logic        rst_b;

    tbl[0] = '{8'hA5, 16'd1, 2'b00, 1'b0, 16'd1, 2'b00, 1'b0, 1'b0, 1'b0, 80};
    tbl[1] = '{8'h03, 16'd2, 2'b01, 1'b1, 16'd2, 2'b01, 1'b1, 1'b1, 1'b0, 192};
    tbl[2] = '{8'h03, 16'd2, 2'b10, 1'b1, 16'd2, 2'b10, 1'b1, 1'b1, 1'b1, 192};
    tbl[3] = '{8'h03, 16'd2, 2'b01, 1'b0, 16'd7, 2'b00, 1'b1, 1'b1, 1'b0, 176};
    tbl[4] = '{8'h5A, 16'd0, 2'b11, 1'b0, 16'd5, 2'b01, 1'b1, 1'b0, 1'b0, 80};
    tbl[5] = '{8'hFF, 16'd3, 2'b10, 1'b0, 16'd1, 2'b00, 1'b1, 1'b1, 1'b1, 264};
    tbl[6] = '{8'h00, 16'd1, 2'b01, 1'b1, 16'd0, 2'b10, 1'b0, 1'b1, 1'b0, 96};
    tbl[7] = '{8'h96, 16'd1, 2'b10, 1'b0, 16'd1, 2'b10, 1'b0, 1'b1, 1'b1, 88};

    // reset values, then tready rises on the first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset {txd,busy,tready,done}",
             int'({txd, busy, s_axis_tready, tx_done}), int'(4'b1000));
    rst = 1'b0;
    @(negedge clk);
    check_eq("tready after reset release", int'(s_axis_tready), 1);

    foreach (tbl[i]) begin
      pat = build_bits(tbl[i].data, tbl[i].exp_has_par, tbl[i].exp_par, tbl[i].stop, nbits);
      run_frame(tbl[i].data, tbl[i].presc, tbl[i].pmode, tbl[i].stop, tbl[i].mid_presc,
                tbl[i].mid_pmode, tbl[i].mid_stop, 1'b0, pat, nbits, tbl[i].exp_len,
                $sformatf("vec%0d", i));
    end

    // back-to-back with tvalid held: 0x00 then 0xFF at prescale 1
    s_axis_tdata  = 8'h00;
    prescale      = 16'd1;
    parity_mode   = 2'b00;
    stop_bits     = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !s_axis_tready; i++) @(negedge clk);
    check_eq("b2b first ready", int'(s_axis_tready), 1);
    @(posedge clk);
    #1;
    s_axis_tdata = 8'hFF;
    pat = build_bits(8'h00, 1'b0, 1'b0, 1'b0, nbits);
    for (int k = 0; k < nbits; k++) repeat (8) exp_q.push_back(pat[k]);
    exp_q.push_back(1'b1);
    pat = build_bits(8'hFF, 1'b0, 1'b0, 1'b0, nbits);
    for (int k = 0; k < nbits; k++) repeat (8) exp_q.push_back(pat[k]);
    exp_q.push_back(1'b1);
    prev = 1'b1; fall1 = 0; fall2 = 0; rdy_cnt = 0; done_cnt = 0; done_last = 0;
    mism = 0; n = 0; seen_rdy = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (seen_rdy) s_axis_tvalid = 1'b0;
      if (txd !== exp_q.pop_front()) mism++;
      if (prev && !txd) begin
        if (fall1 == 0) fall1 = n;
        else if (fall2 == 0) fall2 = n;
      end
      prev = txd;
      if (s_axis_tready) begin
        rdy_cnt++;
        if (n < 100) seen_rdy = 1'b1;
      end
      if (tx_done) begin
        done_cnt++;
        done_last = n;
      end
    end
    s_axis_tvalid = 1'b0;
    check_eq("b2b txd mismatches", mism, 0);
    check_eq("b2b start spacing", fall2 - fall1, 81);
    check_eq("b2b tready pulses", rdy_cnt, 2);
    check_eq("b2b tx_done count", done_cnt, 2);
    check_eq("b2b last tx_done cycle", done_last, 161);

    // break requested mid-frame: frame completes, then line held low
    pat = build_bits(8'hC3, 1'b1, 1'b0, 1'b0, nbits);
    run_frame(8'hC3, 16'd1, 2'b01, 1'b0, 16'd1, 2'b01, 1'b0, 1'b1, pat, nbits, 88, "brk");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b0 || s_axis_tready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_eq("break hold violations", bad, 0);
    break_req = 1'b0;
    @(negedge clk);
    check_eq("break release {txd,busy}", int'({txd, busy}), int'(2'b10));
    @(negedge clk);
    check_eq("break release tready", int'(s_axis_tready), 1);

    // reset during data bit 3 abandons the frame
    start_word(8'h96, 16'd1, 2'b00, 1'b0, ok);
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid reset {txd,busy,done}", int'({txd, busy, tx_done}), int'(3'b100));
    rst = 1'b0;
    done_cnt = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_done) done_cnt++;
      if (!txd) bad++;
    end
    check_eq("mid reset no tx_done", done_cnt, 0);
    check_eq("mid reset line idle", bad, 0);
    pat = build_bits(8'h5A, 1'b0, 1'b0, 1'b0, nbits);
    run_frame(8'h5A, 16'd1, 2'b00, 1'b0, 16'd1, 2'b00, 1'b0, 1'b0, pat, nbits, 80, "after_rst");

    // randomized frames with random mid-frame config changes
    for (int i = 0; i < 24; i++) begin
      rd    = 8'($urandom);
      rp    = 16'($urandom_range(0, 3));
      rpm   = 2'($urandom_range(0, 3));
      rst_b = 1'($urandom_range(0, 1));
      p_eff = (rp == 0) ? 1 : int'(rp);
      has_par = (rpm == 2'b01) || (rpm == 2'b10);
      ones = $countones(rd);
      par  = (rpm == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      pat  = build_bits(rd, has_par, par, rst_b, nbits);
      run_frame(rd, rp, rpm, rst_b, 16'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0, pat, nbits, nbits * p_eff * 8,
                $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
